// File: rtl/lc3_mem_ctrl.sv
// LC-3 main memory behind MAR/MDR: latched request, programmable wait states,
// one-cycle ready pulse, out-of-range flag and busy status.
module lc3_mem_ctrl #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int DEPTH       = 65536,
  parameter int WAIT_CYCLES = 2,
  parameter int INIT_MODE   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_ready,
  output logic              err,
  output logic              busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [ADDR_W:0]  DEPTH_L  = (ADDR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic              mem_ready_q;
  logic              err_q;
  logic              busy_q;
  logic              rd_zero_q;
  logic [DATA_W-1:0] rd_key_q;
  logic [DATA_W-1:0] rd_raw_q;

  // Storage powers up zero; words are kept xor'd with the init image so that
  // INIT_MODE=1 reads back mem[i]=i without any preload pass.
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              accept;
  logic              enter_resp;
  logic              op_we;
  logic              op_in_range;
  logic [ADDR_W-1:0] op_addr;
  logic [DATA_W-1:0] op_wdata;
  logic [DATA_W-1:0] op_key;
  logic [IDX_W-1:0]  op_idx;

  // With zero wait states the access commits on the acceptance edge itself,
  // so the operand mux forwards the live inputs while still in IDLE.
  always_comb begin
    accept      = (state_q == S_IDLE) && req_valid;
    enter_resp  = reset && ((accept && (WAIT_CYCLES == 0)) ||
                            ((state_q == S_WAIT) && (cnt_q == CNT_ONE)));
    op_addr     = (state_q == S_IDLE) ? addr   : addr_q;
    op_we       = (state_q == S_IDLE) ? req_we : we_q;
    op_wdata    = (state_q == S_IDLE) ? wdata  : wdata_q;
    op_in_range = {1'b0, op_addr} < DEPTH_L;
    op_idx      = op_addr[IDX_W-1:0];
    op_key      = (INIT_MODE == 1) ? DATA_W'(op_idx) : '0;
  end

  always_ff @(posedge clk) begin
    if (enter_resp && op_we && op_in_range) begin
      mem_q[op_idx] <= op_wdata ^ op_key;
    end
    if (enter_resp && !op_we && op_in_range) begin
      rd_raw_q <= mem_q[op_idx];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      mem_ready_q <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      rd_zero_q   <= 1'b1;
      rd_key_q    <= '0;
    end else begin
      mem_ready_q <= 1'b0;
      err_q       <= 1'b0;
      if (enter_resp) begin
        mem_ready_q <= 1'b1;
        err_q       <= !op_in_range;
        if (!op_we) begin
          rd_zero_q <= !op_in_range;
          rd_key_q  <= op_key;
        end
      end
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            addr_q  <= addr;
            we_q    <= req_we;
            wdata_q <= wdata;
            cnt_q   <= CNT_LOAD;
            busy_q  <= 1'b1;
            state_q <= (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_q <= S_RESP;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rdata     = rd_zero_q ? '0 : (rd_raw_q ^ rd_key_q);
  assign mem_ready = mem_ready_q;
  assign err       = err_q;
  assign busy      = busy_q;

endmodule
